pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle/bubble MIPS datapath. It holds the architectural PC and computes the next fetch address from branch, jump, jump-register and redirect controls. It adds stall support, a synchronous reset vector, and a small return-address stack (RAS) that predicts `jr $ra` targets. It sits between the fetch stage (it drives the instruction memory address) and the control/ALU outputs of the current instruction.

---
 rtl/pc_unit.sv | 93 +++++++++
 tb/tb_pc_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter for the MIPS datapath.
// It selects the next fetch address from branch, jump, jr and redirect controls.
// It also supports stall, a synchronous reset vector, and a return-address
// stack that predicts jr $ra targets.
module pc_unit #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic [31:0]                        instruction,
  input  logic                               Branch,
  input  logic                               Bne,
  input  logic                               zero,
  input  logic                               Jump,
  input  logic                               Link,
  input  logic                               JumpReg,
  input  logic                               Ret,
  input  logic [XLEN-1:0]                    reg_target,
  input  logic                               redirect,
  input  logic [XLEN-1:0]                    redirect_pc,
  output logic [XLEN-1:0]                    pc,
  output logic [XLEN-1:0]                    pc_plus4,
  output logic [XLEN-1:0]                    next_pc,
  output logic                               ras_hit,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] r_tgt;
  logic            taken;
  logic            ras_valid;
  logic            accept;
  logic            push;
  logic            pop;

  assign pc_plus4 = pc + XLEN'(4);

  // Target computation, next-PC priority mux and RAS push/pop decode
  always_comb begin
    ras_valid = (ras_count != CW'(0));
    taken     = Branch & (zero ^ Bne);
    br_tgt    = pc_plus4 + {{(XLEN-18){instruction[15]}}, instruction[15:0], 2'b00};
    j_tgt     = {pc_plus4[XLEN-1:28], instruction[25:0], 2'b00};
    ras_hit   = JumpReg & Ret & ras_valid;
    r_tgt     = ras_hit ? ras[ptr] : {reg_target[XLEN-1:2], 2'b00};
    ptr_inc   = (ptr == PW'(RAS_DEPTH - 1)) ? PW'(0) : ptr + PW'(1);
    ptr_dec   = (ptr == PW'(0)) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);
    accept    = !stall | redirect;
    push      = accept & !redirect & Jump & Link & !JumpReg;
    pop       = accept & !redirect & ras_hit;

    next_pc = pc_plus4;
    if (redirect)     next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    else if (JumpReg) next_pc = r_tgt;
    else if (Jump)    next_pc = j_tgt;
    else if (taken)   next_pc = br_tgt;
  end

  // PC, RAS pointer and saturating RAS count
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ptr       <= '0;
      ras_count <= '0;
    end else if (accept) begin
      pc <= next_pc;
      if (push) begin
        ptr <= ptr_inc;
        if (ras_count != CW'(RAS_DEPTH)) ras_count <= ras_count + CW'(1);
      end else if (pop) begin
        ptr       <= ptr_dec;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // RAS storage; a push on a full stack overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (!rst && push) ras[ptr_inc] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes expectations, a monitor checks them.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, Branch, Bne, zero, Jump, Link, JumpReg, Ret, redirect;
  logic [31:0] instruction, reg_target, redirect_pc;
  logic [31:0] pc, pc_plus4, next_pc;
  logic        ras_hit;
  logic [2:0]  ras_count;

  pc_unit #(.XLEN(32), .RESET_PC(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instruction(instruction),
    .Branch(Branch), .Bne(Bne), .zero(zero), .Jump(Jump), .Link(Link),
    .JumpReg(JumpReg), .Ret(Ret), .reg_target(reg_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc),
    .ras_hit(ras_hit), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    bit          is_hit;
    logic [31:0] pc;
    int          cnt;
    bit          hit;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.is_hit) begin
        checks++;
        if (ras_hit !== e.hit) begin
          errors++;
          $display("FAIL %s ras_hit got=%0b exp=%0b", e.name, ras_hit, e.hit);
        end
      end else begin
        checks++;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL %s pc got=%h exp=%h", e.name, pc, e.pc);
        end
        checks++;
        if (int'(ras_count) != e.cnt) begin
          errors++;
          $display("FAIL %s ras_count got=%0d exp=%0d", e.name, ras_count, e.cnt);
        end
      end
    end
  end

  task automatic idle();
    rst = 0; stall = 0; Branch = 0; Bne = 0; zero = 0; Jump = 0; Link = 0;
    JumpReg = 0; Ret = 0; redirect = 0;
    instruction = '0; reg_target = '0; redirect_pc = '0;
  endtask

  // Apply current inputs for one cycle; expect pc/count after the edge
  task automatic go(input string name, input logic [31:0] epc, input int ecnt,
                    input bit chk_hit = 0, input bit ehit = 0);
    exp_t e;
    if (chk_hit) begin
      e.cyc = cyc; e.name = name; e.is_hit = 1; e.pc = '0; e.cnt = 0; e.hit = ehit;
      q.push_back(e);
    end
    e.cyc = cyc + 1; e.name = name; e.is_hit = 0; e.pc = epc; e.cnt = ecnt; e.hit = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] target, input int ecnt);
    idle(); redirect = 1; redirect_pc = target;
    go("redir", {target[31:2], 2'b00}, ecnt);
  endtask

  task automatic jal(input string name, input logic [31:0] target, input int ecnt);
    idle(); Jump = 1; Link = 1; instruction = {6'b000011, target[27:2]};
    go(name, target, ecnt);
  endtask

  task automatic ret(input string name, input logic [31:0] rt, input logic [31:0] epc,
                     input int ecnt, input bit ehit);
    idle(); JumpReg = 1; Ret = 1; reg_target = rt;
    go(name, epc, ecnt, 1, ehit);
  endtask

  initial begin
    idle();
    rst = 1;
    go("reset", 32'h100, 0);
    idle(); go("seq1", 32'h104, 0);
    go("seq2", 32'h108, 0);
    go("seq3", 32'h10C, 0);

    // Branches
    redir(32'h200, 0);
    idle(); Branch = 1; zero = 1; instruction = 32'h0000_FFFE;
    go("beq_back", 32'h1FC, 0);
    redir(32'h200, 0);
    idle(); Branch = 1; Bne = 1; zero = 1; instruction = 32'h0000_FFFE;
    go("bne_not", 32'h204, 0);
    redir(32'h200, 0);
    idle(); Branch = 1; Bne = 1; zero = 0; instruction = 32'h0000_0003;
    go("bne_fwd", 32'h210, 0);

    // Jumps, including jump beating a taken branch
    redir(32'h3000_0010, 0);
    idle(); Jump = 1; instruction = 32'h0800_0040;
    go("j", 32'h3000_0100, 0);
    redir(32'h3000_0010, 0);
    idle(); Jump = 1; Branch = 1; zero = 1; instruction = 32'h0800_0040;
    go("j_vs_br", 32'h3000_0100, 0);

    // Call / return
    redir(32'h400, 0);
    jal("jal1", 32'h800, 1);
    jal("jal2", 32'h1000, 2);
    ret("ret1", 32'hDEAD, 32'h804, 1, 1);
    ret("ret2", 32'hDEAD, 32'h404, 0, 1);
    ret("ret3", 32'hDEAD, 32'hDEAC, 0, 0);

    // RAS overflow: links 0x1004,0x2004,0x3004,0x4004,0x5004
    redir(32'h1000, 0);
    jal("ovf_a", 32'h2000, 1);
    jal("ovf_b", 32'h3000, 2);
    jal("ovf_c", 32'h4000, 3);
    jal("ovf_d", 32'h5000, 4);
    jal("ovf_e", 32'h6000, 4);
    ret("ovr_e", 32'h7777, 32'h5004, 3, 1);
    ret("ovr_d", 32'h7777, 32'h4004, 2, 1);
    ret("ovr_c", 32'h7777, 32'h3004, 1, 1);
    ret("ovr_b", 32'h7777, 32'h2004, 0, 1);
    ret("ovr_empty", 32'h7777, 32'h7774, 0, 0);

    // Stall, redirect under stall, RAS retained
    jal("jal_pre", 32'h2000, 1);
    for (int i = 0; i < 4; i++) begin
      idle(); stall = 1; Jump = 1; Link = 1; instruction = 32'h0C00_0800;
      go("stall_hold", 32'h2000, 1);
    end
    idle(); stall = 1; Jump = 1; Link = 1; instruction = 32'h0C00_0800;
    redirect = 1; redirect_pc = 32'h8000_0183;
    go("stall_redir", 32'h8000_0180, 1);
    ret("ret_after", 32'h1234, 32'h7778, 0, 1);

    // Reset beats redirect and clears RAS
    jal("jal_pre_rst", 32'h2000, 1);
    idle(); rst = 1; redirect = 1; redirect_pc = 32'h8000_0000;
    go("rst_redir", 32'h100, 0);
    idle(); go("post_rst", 32'h104, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
